// File: rtl/truth_table_checker.sv
// ---------------------------------------------------------------------------
// truth_table_checker
// Drives a 3-bit stimulus vector {L,P,O} through all eight combinations.
// Each vector is held for DWELL cycles. The DUT response x_in is sampled on
// the last dwell cycle of each vector and compared to the EXPECTED truth table.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset; overrides everything
//   start        one-cycle run request, accepted in IDLE or DONE
//   x_in         response of the device under test
//   vec_out[2:0] stimulus {L,P,O}, L is the MSB
//   busy         high while a sweep runs
//   done         high from sweep completion until the next accepted start
//   pass         captured == EXPECTED; meaningful only while done=1
//   captured[7:0] sampled truth table; bits not yet sampled read 0
//   mismatch_cnt[3:0] number of differing bits (0..8)
//   first_bad[2:0]    lowest mismatching vector index, 0 when none
// ---------------------------------------------------------------------------
module truth_table_checker #(
    parameter int unsigned DWELL    = 20,
    parameter logic [7:0]  EXPECTED = 8'h7F
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       x_in,
    output logic [2:0] vec_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] captured,
    output logic [3:0] mismatch_cnt,
    output logic [2:0] first_bad
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned VEC_W = 3;
    localparam int unsigned MCN_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [7:0]         cap_q, cap_d;
    logic [MCN_W-1:0]   mcnt_q, mcnt_d;
    logic [VEC_W-1:0]   fbad_q, fbad_d;

    logic               sample_c;
    logic               miss_c;

    // Next-state and datapath: sample on the final dwell cycle of each vector
    always_comb begin
        state_d  = state_q;
        vec_d    = vec_q;
        cnt_d    = cnt_q;
        cap_d    = cap_q;
        mcnt_d   = mcnt_q;
        fbad_d   = fbad_q;

        sample_c = (state_q == RUN) && (cnt_q == CNT_W'(DWELL - 1));
        miss_c   = (x_in != EXPECTED[vec_q]);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    vec_d   = '0;
                    cnt_d   = '0;
                    cap_d   = '0;
                    mcnt_d  = '0;
                    fbad_d  = '0;
                end
            end
            RUN: begin
                if (sample_c) begin
                    cap_d[vec_q] = x_in;
                    if (miss_c) begin
                        mcnt_d = mcnt_q + MCN_W'(1);
                        // Only the first mismatch of the sweep records its index
                        if (mcnt_q == '0) begin
                            fbad_d = vec_q;
                        end
                    end
                    if (vec_q == VEC_W'(7)) begin
                        // Vector stays at 7 after the sweep; no wrap
                        state_d = DONE;
                    end else begin
                        vec_d = vec_q + VEC_W'(1);
                        cnt_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
        pass_d = done_d && (mcnt_d == '0);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            vec_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            cap_q   <= '0;
            mcnt_q  <= '0;
            fbad_q  <= '0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            cap_q   <= cap_d;
            mcnt_q  <= mcnt_d;
            fbad_q  <= fbad_d;
        end
    end

    assign vec_out      = vec_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign pass         = pass_q;
    assign captured     = cap_q;
    assign mismatch_cnt = mcnt_q;
    assign first_bad    = fbad_q;

endmodule

// File: tb/tb_truth_table_checker.sv
// ---------------------------------------------------------------------------
// tb_truth_table_checker
// Directed bench: one checker with DWELL=20 and one with DWELL=1, each fed
// by a small behavioural model of the device under test (NAND3, stuck-at-1,
// AND3). Expected results are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_truth_table_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // DWELL=20 instance
    logic       a_rst, a_start, a_x;
    logic [2:0] a_vec, a_fbad;
    logic       a_busy, a_done, a_pass;
    logic [7:0] a_cap;
    logic [3:0] a_mcnt;
    int         a_mode;

    // DWELL=1 instance
    logic       b_rst, b_start, b_x;
    logic [2:0] b_vec, b_fbad;
    logic       b_busy, b_done, b_pass;
    logic [7:0] b_cap;
    logic [3:0] b_mcnt;
    int         b_mode;

    // Response model of the device under test: 0 NAND3, 1 stuck-at-1, 2 AND3
    function automatic logic model_x(input int mode, input logic [2:0] v);
        case (mode)
            0:       return ~&v;
            1:       return 1'b1;
            default: return &v;
        endcase
    endfunction

    assign a_x = model_x(a_mode, a_vec);
    assign b_x = model_x(b_mode, b_vec);

    truth_table_checker #(.DWELL(20), .EXPECTED(8'h7F)) u_a (
        .clk(clk), .rst(a_rst), .start(a_start), .x_in(a_x),
        .vec_out(a_vec), .busy(a_busy), .done(a_done), .pass(a_pass),
        .captured(a_cap), .mismatch_cnt(a_mcnt), .first_bad(a_fbad)
    );

    truth_table_checker #(.DWELL(1), .EXPECTED(8'h7F)) u_b (
        .clk(clk), .rst(b_rst), .start(b_start), .x_in(b_x),
        .vec_out(b_vec), .busy(b_busy), .done(b_done), .pass(b_pass),
        .captured(b_cap), .mismatch_cnt(b_mcnt), .first_bad(b_fbad)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero_a(input string tag);
        check_eq({tag, " vec"},   32'(a_vec),  32'd0);
        check_eq({tag, " busy"},  32'(a_busy), 32'd0);
        check_eq({tag, " done"},  32'(a_done), 32'd0);
        check_eq({tag, " pass"},  32'(a_pass), 32'd0);
        check_eq({tag, " cap"},   32'(a_cap),  32'd0);
        check_eq({tag, " mcnt"},  32'(a_mcnt), 32'd0);
        check_eq({tag, " fbad"},  32'(a_fbad), 32'd0);
    endtask

    // Full DWELL=20 sweep; optional start pulses while busy and in the last sample cycle
    task automatic sweep_a(input string tag, input logic [7:0] exp_cap,
                           input logic [3:0] exp_m, input logic [2:0] exp_fb,
                           input logic exp_pass, input bit repulse);
        int k;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        k = 0;
        check_eq({tag, " start busy"}, 32'(a_busy), 32'd1);
        check_eq({tag, " start done"}, 32'(a_done), 32'd0);
        check_eq({tag, " start cap"},  32'(a_cap),  32'd0);
        check_eq({tag, " start mcnt"}, 32'(a_mcnt), 32'd0);
        check_eq({tag, " start fbad"}, 32'(a_fbad), 32'd0);
        while (!a_done && k < 200) begin
            if ((k % 20) == 0 || (k % 20) == 19)
                check_eq({tag, " vec step"}, 32'(a_vec), 32'(k / 20));
            if (repulse && (k == 50 || k == 159)) a_start = 1'b1;
            else                                   a_start = 1'b0;
            tick();
            k++;
        end
        a_start = 1'b0;
        check_eq({tag, " latency"}, 32'(k + 1), 32'd161);
        check_eq({tag, " cap"},   32'(a_cap),  32'(exp_cap));
        check_eq({tag, " mcnt"},  32'(a_mcnt), 32'(exp_m));
        check_eq({tag, " fbad"},  32'(a_fbad), 32'(exp_fb));
        check_eq({tag, " pass"},  32'(a_pass), 32'(exp_pass));
        check_eq({tag, " busy"},  32'(a_busy), 32'd0);
        check_eq({tag, " vec7"},  32'(a_vec),  32'd7);
        tick();
        tick();
        check_eq({tag, " done held"}, 32'(a_done), 32'd1);
        check_eq({tag, " vec held"},  32'(a_vec),  32'd7);
    endtask

    initial begin
        int k;
        a_rst = 1'b1; a_start = 1'b0; a_mode = 0;
        b_rst = 1'b1; b_start = 1'b0; b_mode = 0;
        tick();
        tick();
        check_zero_a("reset");
        a_rst = 1'b0;
        b_rst = 1'b0;
        tick();
        tick();
        check_zero_a("idle");

        // Ideal NAND3 with start pulses while busy and on the final sample
        a_mode = 0;
        sweep_a("nand", 8'h7F, 4'd0, 3'd0, 1'b1, 1'b1);

        // Stuck-at-1; started from DONE
        a_mode = 1;
        sweep_a("stuck1", 8'hFF, 4'd1, 3'd7, 1'b0, 1'b0);

        // AND3: every bit differs
        a_mode = 2;
        sweep_a("and3", 8'h80, 4'd8, 3'd0, 1'b0, 1'b0);

        // Reset in the middle of a sweep
        a_mode = 0;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        k = 0;
        while (a_vec != 3'd4 && k < 200) begin
            tick();
            k++;
        end
        check_eq("mid vec4", 32'(a_vec), 32'd4);
        check_eq("mid partial cap", 32'(a_cap), 32'h0F);
        check_eq("mid busy", 32'(a_busy), 32'd1);
        a_rst = 1'b1;
        a_start = 1'b1;
        tick();
        a_rst = 1'b0;
        a_start = 1'b0;
        check_zero_a("midrst");
        for (int i = 0; i < 5; i++) tick();
        check_zero_a("post rst idle");
        sweep_a("after rst", 8'h7F, 4'd0, 3'd0, 1'b1, 1'b0);

        // DWELL=1: every RUN cycle samples
        b_mode = 0;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        k = 0;
        while (!b_done && k < 50) begin
            check_eq("d1 vec", 32'(b_vec), 32'(k));
            tick();
            k++;
        end
        check_eq("d1 latency", 32'(k + 1), 32'd9);
        check_eq("d1 pass", 32'(b_pass), 32'd1);
        check_eq("d1 cap",  32'(b_cap),  32'h7F);
        check_eq("d1 busy", 32'(b_busy), 32'd0);

        // DWELL=1 with AND3
        b_mode = 2;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        k = 0;
        while (!b_done && k < 50) begin
            tick();
            k++;
        end
        check_eq("d1 and latency", 32'(k + 1), 32'd9);
        check_eq("d1 and cap",  32'(b_cap),  32'h80);
        check_eq("d1 and mcnt", 32'(b_mcnt), 32'd8);
        check_eq("d1 and pass", 32'(b_pass), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    // Concurrent invariants on both instances
    always @(negedge clk) begin
        if (a_busy && a_done) begin
            n_errors++;
            $display("FAIL busy_done_a: busy=%0b done=%0b expected not both", a_busy, a_done);
        end
        if (b_busy && b_done) begin
            n_errors++;
            $display("FAIL busy_done_b: busy=%0b done=%0b expected not both", b_busy, b_done);
        end
    end

endmodule
